// File: rtl/ballot_collector.sv
// ---------------------------------------------------------------------------
// ballot_collector
//
// Front end for the combinational four-person voter. A round is opened with
// `start`, after which each of the four voter stations may hand over exactly
// one vote through a level req / pulsed ack handshake. The assembled 4-bit
// ballot is driven onto the voter's I[3:0] input. Once the ballot is
// complete, or the collection window runs out, the voter's O[3:1] response
// is latched and announced with a one-cycle strobe.
//
// Ports
//   clk           in   1       rising-edge clock
//   rst           in   1       asynchronous reset, active-high
//   start         in   1       open a round (only looked at in IDLE)
//   vote_req      in   4       station i presents a vote, held until acked
//   vote_val      in   4       vote of station i (1 = yes), valid with req
//   vote_ack      out  4       one-cycle accept pulse per station
//   ballot        out  4       registered ballot, feeds voter I[3:0]
//   voted_mask    out  4       stations already accepted this round
//   result_in     in   3       voter O[3:1], combinational from ballot
//   result_out    out  3       latched voter response for the closed round
//   result_valid  out  1       one-cycle strobe: result_out was updated
//   timeout       out  1       last round closed with a missing vote (held)
//   busy          out  1       high whenever the FSM is not in IDLE
//   round_cnt     out  RCNT_W  completed rounds, wraps modulo 2^RCNT_W
// ---------------------------------------------------------------------------
module ballot_collector #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RCNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        vote_req,
  input  logic [3:0]        vote_val,
  output logic [3:0]        vote_ack,
  output logic [3:0]        ballot,
  output logic [3:0]        voted_mask,
  input  logic [2:0]        result_in,
  output logic [2:0]        result_out,
  output logic              result_valid,
  output logic              timeout,
  output logic              busy,
  output logic [RCNT_W-1:0] round_cnt
);

  // The timer only has to reach TIMEOUT_CYCLES-1, so it is sized for that.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EVAL,
    ST_REPORT
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic [3:0] accept;
  logic [3:0] mask_next;
  logic [3:0] ballot_next;

  // Work out which stations get accepted this cycle. A station is accepted
  // only the first time it requests within a round; any later request from
  // the same station is simply ignored, so its first vote can never be
  // overwritten. Several stations may be accepted together.
  always_comb begin
    accept      = vote_req & ~voted_mask;
    mask_next   = voted_mask | accept;
    ballot_next = (ballot & ~accept) | (vote_val & accept);
  end

  // busy is a pure decode of the state register, so it drops in the same
  // instant an asynchronous reset returns the FSM to IDLE.
  assign busy = (state != ST_IDLE);

  // Round sequencer: IDLE -> COLLECT -> EVAL -> REPORT -> IDLE.
  // vote_ack and result_valid are registered pulses: they default low every
  // cycle and are only raised for the single cycle after the event that
  // caused them. result_out and round_cnt survive across rounds; ballot and
  // voted_mask stay visible after REPORT until the next round is opened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      ballot       <= '0;
      voted_mask   <= '0;
      vote_ack     <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      round_cnt    <= '0;
    end else begin
      vote_ack     <= '0;
      result_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_COLLECT;
            ballot     <= '0;
            voted_mask <= '0;
            timer      <= '0;
            timeout    <= 1'b0;
          end
        end

        ST_COLLECT: begin
          ballot     <= ballot_next;
          voted_mask <= mask_next;
          vote_ack   <= accept;
          // A complete mask wins over the timer, so a last vote landing in
          // the final window cycle still closes the round without timeout.
          // Missing stations keep their cleared ballot bit (abstain = no).
          if (mask_next == 4'b1111) begin
            state <= ST_EVAL;
          end else if (timer == TIMER_LAST) begin
            state   <= ST_EVAL;
            timeout <= 1'b1;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        ST_EVAL: begin
          // ballot has been stable for a full cycle, so the voter output
          // has settled and can be captured.
          result_out   <= result_in;
          result_valid <= 1'b1;
          state        <= ST_REPORT;
        end

        ST_REPORT: begin
          round_cnt <= round_cnt + RCNT_W'(1);
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_collector.sv
// ---------------------------------------------------------------------------
// tb_ballot_collector
//
// Directed bench for ballot_collector. A small combinational voter model
// stands in for the real four-person voter on result_in. Most rounds are
// described as a table of per-cycle vectors; the reset, timeout and
// counter-wrap scenarios are written out by hand.
// ---------------------------------------------------------------------------
module tb_ballot_collector;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int RCNT_W         = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        vote_req;
  logic [3:0]        vote_val;
  logic [3:0]        vote_ack;
  logic [3:0]        ballot;
  logic [3:0]        voted_mask;
  logic [2:0]        result_in;
  logic [2:0]        result_out;
  logic              result_valid;
  logic              timeout;
  logic              busy;
  logic [RCNT_W-1:0] round_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic        start;
    logic [3:0]  req;
    logic [3:0]  val;
    logic [3:0]  ack;
    logic [3:0]  bal;
    logic [3:0]  mask;
    logic [2:0]  rout;
    logic        rv;
    logic        tmo;
    logic        bsy;
    logic [7:0]  rcnt;
  } vec_t;

  vec_t tbl[$];

  ballot_collector #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .RCNT_W        (RCNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vote_req    (vote_req),
    .vote_val    (vote_val),
    .vote_ack    (vote_ack),
    .ballot      (ballot),
    .voted_mask  (voted_mask),
    .result_in   (result_in),
    .result_out  (result_out),
    .result_valid(result_valid),
    .timeout     (timeout),
    .busy        (busy),
    .round_cnt   (round_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in voter: O3 = clear majority yes, O2 = tie, O1 = clear majority no.
  function automatic logic [2:0] voterModel(input logic [3:0] b);
    int y;
    y = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
    return {(y >= 3), (y == 2), (y <= 1)};
  endfunction

  always_comb result_in = voterModel(ballot);

  function automatic vec_t mk(input string n, input logic s,
                              input logic [3:0] rq, input logic [3:0] vl,
                              input logic [3:0] ak, input logic [3:0] bl,
                              input logic [3:0] mk_, input logic [2:0] ro,
                              input logic rvv, input logic tm,
                              input logic bs, input logic [7:0] rc);
    vec_t v;
    v.name = n;  v.start = s;  v.req = rq;  v.val = vl;
    v.ack = ak;  v.bal = bl;   v.mask = mk_; v.rout = ro;
    v.rv = rvv;  v.tmo = tm;   v.bsy = bs;   v.rcnt = rc;
    return v;
  endfunction

  // Drive inputs, then move to 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic s, input logic [3:0] rq,
                               input logic [3:0] vl);
    start    = s;
    vote_req = rq;
    vote_val = vl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [25:0] got;
    logic [25:0] want;
    got  = {vote_ack, ballot, voted_mask, result_out, result_valid,
            timeout, busy, round_cnt};
    want = {v.ack, v.bal, v.mask, v.rout, v.rv, v.tmo, v.bsy, v.rcnt};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got ack=%b ballot=%b mask=%b rout=%b rv=%b tmo=%b busy=%b rcnt=%0d, want ack=%b ballot=%b mask=%b rout=%b rv=%b tmo=%b busy=%b rcnt=%0d",
               v.name, vote_ack, ballot, voted_mask, result_out, result_valid,
               timeout, busy, round_cnt, v.ack, v.bal, v.mask, v.rout, v.rv,
               v.tmo, v.bsy, v.rcnt);
    end
  endtask

  // One fast round with all four stations voting yes together.
  task automatic quickRound();
    int n;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b1111);
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      n++;
    end
    if (busy !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL quick_round: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    vote_req = '0;
    vote_val = '0;

    // Test 2: four single votes 1,0,1,1
    tbl.push_back(mk("t2_start", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk("t2_v0",    0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk("t2_v1",    0, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 4'b0011, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk("t2_v2",    0, 4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0111, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk("t2_v3",    0, 4'b1000, 4'b1000, 4'b1000, 4'b1101, 4'b1111, 3'b000, 0, 0, 1, 0));
    tbl.push_back(mk("t2_eval",  0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b1111, 3'b100, 1, 0, 1, 0));
    tbl.push_back(mk("t2_idle",  0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b1111, 3'b100, 0, 0, 0, 1));
    // Test 3: all four at once, start pulsed in EVAL and REPORT
    tbl.push_back(mk("t3_start", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b100, 0, 0, 1, 1));
    tbl.push_back(mk("t3_all",   0, 4'b1111, 4'b0110, 4'b1111, 4'b0110, 4'b1111, 3'b100, 0, 0, 1, 1));
    tbl.push_back(mk("t3_evst",  1, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b1111, 3'b010, 1, 0, 1, 1));
    tbl.push_back(mk("t3_rpst",  1, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b1111, 3'b010, 0, 0, 0, 2));
    tbl.push_back(mk("t3_idle",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b1111, 3'b010, 0, 0, 0, 2));
    // Test 5: station 1 keeps requesting with a changed value
    tbl.push_back(mk("t5_start", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'b010, 0, 0, 1, 2));
    tbl.push_back(mk("t5_s1",    0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 3'b010, 0, 0, 1, 2));
    tbl.push_back(mk("t5_s1rep", 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 3'b010, 0, 0, 1, 2));
    tbl.push_back(mk("t5_s0",    0, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 3'b010, 0, 0, 1, 2));
    tbl.push_back(mk("t5_s23",   0, 4'b1110, 4'b1100, 4'b1100, 4'b1110, 4'b1111, 3'b010, 0, 0, 1, 2));
    tbl.push_back(mk("t5_eval",  0, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b1111, 3'b100, 1, 0, 1, 2));
    tbl.push_back(mk("t5_idle",  0, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b1111, 3'b100, 0, 0, 0, 3));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput(mk("reset", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0, 0, 0, 0));
    rst = 1'b0;

    // Test 1: asynchronous reset in the middle of COLLECT
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0101, 4'b0101);
    checkOutput(mk("t1_pre", 0, 0, 0, 4'b0101, 4'b0101, 4'b0101, 3'b000, 0, 0, 1, 0));
    vote_req = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    checkOutput(mk("t1_rst", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven rounds
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].start, tbl[i].req, tbl[i].val);
      checkOutput(tbl[i]);
    end

    // Test 4: only station 2 votes, round closes on the timer
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput(mk("t4_start", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b100, 0, 0, 1, 3));
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    checkOutput(mk("t4_vote", 0, 0, 0, 4'b0100, 4'b0100, 4'b0100, 3'b100, 0, 0, 1, 3));
    for (int k = 2; k <= 15; k++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      checkOutput(mk("t4_wait", 0, 0, 0, 4'b0000, 4'b0100, 4'b0100, 3'b100, 0, 0, 1, 3));
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput(mk("t4_tmo", 0, 0, 0, 4'b0000, 4'b0100, 4'b0100, 3'b100, 0, 1, 1, 3));
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput(mk("t4_report", 0, 0, 0, 4'b0000, 4'b0100, 4'b0100, 3'b001, 1, 1, 1, 3));
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput(mk("t4_idle", 0, 0, 0, 4'b0000, 4'b0100, 4'b0100, 3'b001, 0, 1, 0, 4));
    applyStimulus(1'b0, 4'b1111, 4'b1111);
    checkOutput(mk("idle_req", 0, 0, 0, 4'b0000, 4'b0100, 4'b0100, 3'b001, 0, 1, 0, 4));

    // Last vote lands in the final window cycle: no timeout
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkOutput(mk("late_start", 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 3'b001, 0, 0, 1, 4));
    applyStimulus(1'b0, 4'b0111, 4'b0000);
    checkOutput(mk("late_three", 0, 0, 0, 4'b0111, 4'b0000, 4'b0111, 3'b001, 0, 0, 1, 4));
    for (int k = 2; k <= 15; k++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      checkOutput(mk("late_wait", 0, 0, 0, 4'b0000, 4'b0000, 4'b0111, 3'b001, 0, 0, 1, 4));
    end
    applyStimulus(1'b0, 4'b1000, 4'b1000);
    checkOutput(mk("late_last", 0, 0, 0, 4'b1000, 4'b1000, 4'b1111, 3'b001, 0, 0, 1, 4));
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput(mk("late_report", 0, 0, 0, 4'b0000, 4'b1000, 4'b1111, 3'b001, 1, 0, 1, 4));
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput(mk("late_idle", 0, 0, 0, 4'b0000, 4'b1000, 4'b1111, 3'b001, 0, 0, 0, 5));

    // Test 6: counter wrap after 2^RCNT_W + 1 completed rounds in total
    for (int r = 5; r < 255; r++) quickRound();
    checkOutput(mk("wrap_255", 0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 3'b100, 0, 0, 0, 8'd255));
    quickRound();
    checkOutput(mk("wrap_0", 0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 3'b100, 0, 0, 0, 8'd0));
    quickRound();
    checkOutput(mk("wrap_1", 0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 3'b100, 0, 0, 0, 8'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
